axi_wbuf_burst: RTL and testbench
=================================

Name: axi_wbuf_burst

Overview:
- Parametrised AXI write-back buffer. Sits between the cache miss/evict controller and the AXI master port.
- Captures one dirty line, or one uncached word with byte strobes, in a single cycle.
- Drives the full AW/W/B sequence itself and honours wready back-pressure.
- Holds a sticky completion flag until the controller acknowledges it.

Parameters:
- LINE_WIDTH, 512, bits per cache line; must be an integer multiple of DATA_WIDTH.
- DATA_WIDTH, 32, AXI W data width; power of two, 8..256.
- ADDR_WIDTH, 32, AXI address width.
- Derived: BEATS = LINE_WIDTH/DATA_WIDTH. BEATS must be a power of two and at most 256.
- Derived: CW = max(1, clog2(BEATS)) beat-counter width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  write request
- req_ready  out  1  buffer idle; request accepted when req_valid && req_ready
- req_uncache  in  1  1 = single-beat uncached write, 0 = full-line burst
- req_addr  in  ADDR_WIDTH  target byte address
- req_line  in  LINE_WIDTH  line data; uncached data is taken from bits [DATA_WIDTH-1:0]
- req_strb  in  DATA_WIDTH/8  byte strobes, uncached only
- awvalid  out  1  AXI AW valid
- awready  in  1  AXI AW ready
- awaddr  out  ADDR_WIDTH  AXI address
- awlen  out  8  AXI burst length minus one
- awsize  out  3  AXI beat size, clog2(DATA_WIDTH/8)
- awburst  out  2  constant 2'b01 (INCR)
- wvalid  out  1  AXI W valid
- wready  in  1  AXI W ready
- wdata  out  DATA_WIDTH  beat data
- wstrb  out  DATA_WIDTH/8  beat strobes
- wlast  out  1  last beat
- bvalid  in  1  AXI B valid
- bready  out  1  AXI B ready
- bresp  in  2  AXI write response
- done  out  1  transaction complete, sticky
- done_ack  in  1  clears done

Behaviour:
- States: IDLE, ADDR, DATA, RESP, DONE. All outputs decode from the registered state, counter and capture registers. No input-to-output combinational path except the handshakes into the next-state logic.
- Reset: rstn low asynchronously forces IDLE and clears the counter and all capture registers. Outputs during reset: req_ready=1; awvalid, wvalid, wlast, bready and done all 0. A reset mid-burst abandons the transaction with no recovery; this is legal only at system reset.
- IDLE: req_ready=1. On req_valid, latch req_line, req_uncache, req_strb and the address, then go to ADDR the next cycle.
- Address latching: cached requests store the address with the low clog2(LINE_WIDTH/8) bits zeroed. Uncached requests store the address unmodified.
- ADDR: awvalid=1. awlen = uncache ? 0 : BEATS-1. awaddr, awlen, awsize and awburst are held stable while awvalid && !awready. Go to DATA on awready.
- DATA: wvalid=1.
  - wdata = slice [cnt*DATA_WIDTH +: DATA_WIDTH] of the latched line.
  - wstrb = uncache ? latched strb : all ones.
  - wlast = uncache ? 1 : (cnt == BEATS-1).
  - cnt increments only on wvalid && wready, so data is held stable under back-pressure.
  - The handshake on the wlast beat moves to RESP and clears cnt. The W channel never starts before the AW handshake.
- RESP: bready=1. Go to DONE on bvalid. bresp is ignored unless the optional feature is enabled.
- DONE: done=1 and req_ready=0. Go to IDLE on done_ack. done_ack arriving in the same cycle as bvalid has no effect. req_valid is ignored outside IDLE.
- Latency: an uncached write with zero-wait slave takes 4 cycles from acceptance to done (ADDR, DATA, RESP, DONE). A cached line takes BEATS+3 cycles.
- Corner cases:
  - BEATS=1 degenerates to a single-beat burst: awlen=0 and wlast=1 on the first beat.
  - Counter wrap is impossible because the exit happens on the last beat.

Optional Feature:
- Macro WBUF_BRESP_ERR_EN.
- Defined: adds output resp_err (1 bit). It is latched on the B handshake as (bresp[1]==1), i.e. SLVERR or DECERR. It is valid while done=1 and cleared on the done_ack transition and on reset.
- Undefined: the resp_err port does not exist and bresp is unused.

Test Plan:
- Cached write, LINE_WIDTH=512, DATA_WIDTH=32, awaddr input 0x1000_0024 -> awaddr=0x1000_0000, awlen=15, awsize=2, 16 beats with wdata = successive words of req_line, wlast only on beat 16, wstrb=4'hF, done 19 cycles after acceptance.
- Uncached write, addr 0x1FD0_0004, strb 4'b0011, line[31:0]=0xDEADBEEF -> awlen=0, one beat wdata=0xDEADBEEF, wstrb=4'b0011, wlast=1, done after 4 cycles.
- Back-pressure: awready held low 3 cycles and wready toggling 1,0,0,1 during the burst -> AW and W outputs stable while stalled, no beat skipped or repeated, 16 beats total.
- bvalid delayed 5 cycles, then done_ack withheld 4 cycles -> bready high throughout RESP, done held high, req_ready=0 and req_valid ignored until done_ack.
- rstn pulsed low at beat 7 of a burst -> all of awvalid, wvalid, wlast, bready and done immediately 0, req_ready=1. A new request afterwards restarts at beat 0.
- With WBUF_BRESP_ERR_EN defined, bresp=2'b10 -> resp_err=1 with done. The next transaction with bresp=2'b00 -> resp_err=0.

Source files
------------

// File: rtl/axi_wbuf_burst.sv
// AXI write-back buffer: captures one dirty line or one uncached strobed word and runs AW/W/B.
// Optional WBUF_BRESP_ERR_EN adds a resp_err output latched from bresp[1] on the B handshake.
module axi_wbuf_burst #(
    parameter int unsigned LINE_WIDTH = 512,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_uncache,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [LINE_WIDTH-1:0]   req_line,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp,
    output logic                    done,
    input  logic                    done_ack
`ifdef WBUF_BRESP_ERR_EN
   ,output logic                    resp_err
`endif
);

    localparam int unsigned BEATS = LINE_WIDTH / DATA_WIDTH;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned SW    = DATA_WIDTH / 8;
    localparam int unsigned OFFW  = $clog2(LINE_WIDTH / 8);
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [LINE_WIDTH-1:0] line_q;
    logic                  uncache_q;

    // Line is shifted down one beat per W handshake, so the current beat is always the low word.
    assign wdata   = line_q[DATA_WIDTH-1:0];
    assign awsize  = 3'($clog2(SW));
    assign awburst = 2'b01;

    logic unused_bresp;
    assign unused_bresp = ^bresp;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            line_q    <= '0;
            uncache_q <= 1'b0;
            req_ready <= 1'b1;
            awvalid   <= 1'b0;
            awaddr    <= '0;
            awlen     <= '0;
            wvalid    <= 1'b0;
            wstrb     <= '0;
            wlast     <= 1'b0;
            bready    <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        line_q    <= req_line;
                        uncache_q <= req_uncache;
                        awaddr    <= req_uncache ? req_addr
                                                 : {req_addr[ADDR_WIDTH-1:OFFW], OFFW'(0)};
                        awlen     <= req_uncache ? 8'd0 : 8'(BEATS - 1);
                        wstrb     <= req_uncache ? req_strb : {SW{1'b1}};
                        req_ready <= 1'b0;
                        awvalid   <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        cnt     <= '0;
                        wlast   <= uncache_q || (BEATS == 1);
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (wready) begin
                        if (wlast) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            cnt    <= '0;
                            bready <= 1'b1;
                            state  <= RESP;
                        end else begin
                            cnt    <= cnt + CW'(1);
                            line_q <= line_q >> DATA_WIDTH;
                            wlast  <= ((cnt + CW'(1)) == LAST_CNT);
                        end
                    end
                end
                RESP: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (done_ack) begin
                        done      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    awvalid   <= 1'b0;
                    wvalid    <= 1'b0;
                    wlast     <= 1'b0;
                    bready    <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

`ifdef WBUF_BRESP_ERR_EN
    // Error flag follows the done flag's lifetime.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_err <= 1'b0;
        end else if (state == RESP && bvalid) begin
            resp_err <= bresp[1];
        end else if (state == DONE && done_ack) begin
            resp_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_axi_wbuf_burst.sv
// Table-driven bench for axi_wbuf_burst with a W-beat scoreboard and a small AXI slave model.
module tb_axi_wbuf_burst;

    logic         clk = 1'b0;
    logic         rstn;
    logic         req_valid, req_ready, req_uncache;
    logic [31:0]  req_addr;
    logic [511:0] req_line;
    logic [3:0]   req_strb;
    logic         awvalid, awready;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         wvalid, wready, wlast;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         bvalid, bready;
    logic [1:0]   bresp;
    logic         done, done_ack;
`ifdef WBUF_BRESP_ERR_EN
    logic         resp_err;
`endif

    axi_wbuf_burst dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_uncache(req_uncache),
        .req_addr(req_addr), .req_line(req_line), .req_strb(req_strb),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .done(done), .done_ack(done_ack)
`ifdef WBUF_BRESP_ERR_EN
       ,.resp_err(resp_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         unc;
        logic [31:0]  addr;
        logic [511:0] line;
        logic [3:0]   strb;
        int           aw_stall;
        bit           wtog;
        int           b_delay;
        int           ack_delay;
        bit           ack_with_b;
        logic [1:0]   bresp;
        int           abort_beat;
        logic [31:0]  exp_awaddr;
        logic [7:0]   exp_awlen;
        logic [3:0]   exp_wstrb;
        int           exp_beats;
        int           exp_lat;
        bit           exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    vec_t  vecs[7];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] make_line(input logic [31:0] seed);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = seed ^ (32'(i) * 32'h1111_1111);
        return l;
    endfunction

    function automatic vec_t base(input logic unc, input logic [31:0] addr, input logic [31:0] seed);
        vec_t v;
        v.unc = unc;         v.addr = addr;         v.line = make_line(seed);
        v.strb = 4'h0;       v.aw_stall = 0;        v.wtog = 1'b0;
        v.b_delay = 0;       v.ack_delay = 0;       v.ack_with_b = 1'b0;
        v.bresp = 2'b00;     v.abort_beat = 0;
        v.exp_awaddr = unc ? addr : {addr[31:6], 6'd0};
        v.exp_awlen = unc ? 8'd0 : 8'd15;
        v.exp_wstrb = 4'hF;  v.exp_beats = unc ? 1 : 16;
        v.exp_lat = unc ? 4 : 19;
        v.exp_err = 1'b0;
        return v;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_awvalid"}, awvalid, 0);
        chk({tag, "_wvalid"}, wvalid, 0);
        chk({tag, "_wlast"}, wlast, 0);
        chk({tag, "_bready"}, bready, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc = 1, awc = 0, wc = 0, bc = 0, ac = 0, beats = 0;
        bit acked = 0, aw_prev = 0, w_prev = 0;
        logic [31:0] p_awaddr, p_wdata;
        logic [7:0]  p_awlen;
        logic [3:0]  p_wstrb;
        logic        p_wlast;
        beat_t e;
        exp_q.delete();
        for (int b = 0; b < v.exp_beats; b++) begin
            e.d = v.line[b*32 +: 32];
            e.s = v.exp_wstrb;
            e.l = (b == v.exp_beats - 1);
            exp_q.push_back(e);
        end
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1; req_uncache = v.unc; req_addr = v.addr; req_line = v.line; req_strb = v.strb;
        @(posedge clk); #1;
        req_line = ~v.line; req_addr = ~v.addr; req_strb = ~v.strb;
        while (!acked && cyc < 400) begin
            awready = 0; wready = 0; bvalid = 0; done_ack = 0; req_valid = 0;
            if (v.abort_beat > 0 && beats == v.abort_beat) begin
                #2 rstn = 0;
                #1 check_idle_outputs("abort");
                exp_q.delete();
                @(negedge clk) rstn = 1;
                @(posedge clk); #1;
                return;
            end
            if (awvalid) begin
                if (aw_prev) begin
                    chk("aw_hold_addr", awaddr, p_awaddr);
                    chk("aw_hold_len", awlen, p_awlen);
                end else begin
                    chk("awaddr", awaddr, v.exp_awaddr);
                    chk("awlen", awlen, v.exp_awlen);
                    chk("awsize", awsize, 2);
                    chk("awburst", awburst, 1);
                end
                chk("w_before_aw", wvalid, 0);
                awready = (awc >= v.aw_stall); awc++;
                aw_prev = !awready; p_awaddr = awaddr; p_awlen = awlen;
            end
            if (wvalid) begin
                if (w_prev) begin
                    chk("w_hold_data", wdata, p_wdata);
                    chk("w_hold_strb", wstrb, p_wstrb);
                    chk("w_hold_last", wlast, p_wlast);
                end
                wready = v.wtog ? (wc % 4 == 0 || wc % 4 == 3) : 1'b1; wc++;
                w_prev = !wready; p_wdata = wdata; p_wstrb = wstrb; p_wlast = wlast;
                if (wready) begin
                    if (exp_q.size() == 0) chk("w_extra_beat", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("wdata", wdata, e.d);
                        chk("wstrb", wstrb, e.s);
                        chk("wlast", wlast, e.l);
                    end
                    beats++;
                end
            end
            if (bready) begin
                chk("req_ready_resp", req_ready, 0);
                bvalid = (bc >= v.b_delay); bc++; bresp = v.bresp;
                if (bvalid && v.ack_with_b) done_ack = 1;
            end
            if (done) begin
                if (ac == 0) begin
                    chk("latency", cyc, v.exp_lat);
`ifdef WBUF_BRESP_ERR_EN
                    chk("resp_err", resp_err, v.exp_err);
`endif
                end
                chk("req_ready_done", req_ready, 0);
                done_ack = (ac >= v.ack_delay); ac++;
                if (!done_ack) begin
                    req_valid = 1; req_uncache = 1; req_addr = 32'hBAD0_0000;
                end
                acked = done_ack;
            end
            @(posedge clk); #1;
            cyc++;
        end
        done_ack = 0; req_valid = 0;
        chk("timeout", acked, 1);
        chk("done_clear", done, 0);
        chk("req_ready_back", req_ready, 1);
        chk("beat_count", beats, v.exp_beats);
        chk("queue_empty", exp_q.size(), 0);
`ifdef WBUF_BRESP_ERR_EN
        chk("resp_err_clear", resp_err, 0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = base(1'b0, 32'h1000_0024, 32'hA5A5_0000);
        vecs[1] = base(1'b1, 32'h1FD0_0004, 32'h0000_1234);
        vecs[1].line[31:0] = 32'hDEAD_BEEF; vecs[1].strb = 4'b0011; vecs[1].exp_wstrb = 4'b0011;
        vecs[1].bresp = 2'b10; vecs[1].exp_err = 1'b1;
        vecs[2] = base(1'b0, 32'h2000_007C, 32'h3C3C_0F0F);
        vecs[2].aw_stall = 3; vecs[2].wtog = 1'b1; vecs[2].exp_lat = 38;
        vecs[3] = base(1'b0, 32'h3000_0000, 32'h0BAD_F00D);
        vecs[3].b_delay = 5; vecs[3].ack_delay = 4; vecs[3].exp_lat = 24;
        vecs[3].bresp = 2'b11; vecs[3].exp_err = 1'b1;
        vecs[4] = base(1'b1, 32'h4000_0003, 32'h7777_8888);
        vecs[4].strb = 4'b1000; vecs[4].exp_wstrb = 4'b1000; vecs[4].ack_with_b = 1'b1;
        vecs[4].bresp = 2'b01;
        vecs[5] = base(1'b0, 32'h5000_0010, 32'h1357_9BDF);
        vecs[5].abort_beat = 7;
        vecs[6] = base(1'b0, 32'h6000_0038, 32'h2468_ACE0);

        rstn = 0; req_valid = 0; req_uncache = 0; req_addr = '0; req_line = '0; req_strb = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b00; done_ack = 0;
        #12 check_idle_outputs("reset");
        @(negedge clk) rstn = 1;
        @(posedge clk); #1;
        check_idle_outputs("post_reset");

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
